framebuffer_scanout: RTL

FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

---
 rtl/framebuffer_scanout_if.sv | 36 +++
 rtl/framebuffer_scanout.sv | 121 ++++++++++++
 2 files changed

// File: rtl/framebuffer_scanout_if.sv
// framebuffer_scanout_if
//   Bundles the signals between the scanout engine, its two RAMs and the video sink.
//   master (scanout engine):
//     out framebuffer_rgb_addr[16:0]     palette-index RAM read address
//     in  framebuffer_rgb_out[7:0]       index RAM data, one clock after the address
//     out framebuffer_palette_addr[7:0]  palette RAM read address
//     in  framebuffer_palette_out[23:0]  palette RAM data {R,G,B}, one clock after the address
//     out video_rgb[23:0], video_de, video_hsync, video_vsync   (syncs active low)
//     out framebuffer_hblank, framebuffer_vblank                (status flags)
//   slave: the same signals with the directions reversed (RAMs, sink, status reader).
interface framebuffer_scanout_if;
    logic [16:0] framebuffer_rgb_addr;
    logic [7:0]  framebuffer_rgb_out;
    logic [7:0]  framebuffer_palette_addr;
    logic [23:0] framebuffer_palette_out;
    logic [23:0] video_rgb;
    logic        video_de;
    logic        video_hsync;
    logic        video_vsync;
    logic        framebuffer_hblank;
    logic        framebuffer_vblank;

    modport master (
        output framebuffer_rgb_addr, framebuffer_palette_addr,
        output video_rgb, video_de, video_hsync, video_vsync,
        output framebuffer_hblank, framebuffer_vblank,
        input  framebuffer_rgb_out, framebuffer_palette_out
    );

    modport slave (
        input  framebuffer_rgb_addr, framebuffer_palette_addr,
        input  video_rgb, video_de, video_hsync, video_vsync,
        input  framebuffer_hblank, framebuffer_vblank,
        output framebuffer_rgb_out, framebuffer_palette_out
    );
endinterface

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout
//   Generates VGA-style timing and scans a pixel-doubled (2x2) palette-index
//   framebuffer out through a palette RAM.
//   Ports:
//     clk_pixel       pixel clock, the only clock
//     reset_n         asynchronous active-low reset
//     output_enabled  display enable, asynchronous to clk_pixel
//     bus             framebuffer_scanout_if.master: RAM addresses/data, video out, blank flags
//   Pipeline: stage 0 counters drive the index address; index arrives one clock
//   later and is used directly as palette address; colour arrives one clock after
//   that and is captured in the output register. Video outputs therefore trail the
//   counters by exactly 3 clocks.
module framebuffer_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_WIDTH = 320
) (
    input  logic                  clk_pixel,
    input  logic                  reset_n,
    input  logic                  output_enabled,
    framebuffer_scanout_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic [16:0]   line_base;
    logic [16:0]   rgb_addr;
    logic          h_end, v_end, h_vis, v_vis, active;
    logic          hsync_raw, vsync_raw;
    logic [1:0]    oe_sync;
    logic          display_on;
    logic [1:0]    de_pipe, hs_pipe, vs_pipe;

    assign h_end = (h_count == HW'(H_TOTAL - 1));
    assign v_end = (v_count == VW'(V_TOTAL - 1));
    assign h_vis = (h_count < HW'(H_ACTIVE));
    assign v_vis = (v_count < VW'(V_ACTIVE));
    assign active = h_vis && v_vis;
    assign hsync_raw = !((h_count >= HW'(H_ACTIVE + H_FP)) &&
                         (h_count <  HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_raw = !((v_count >= VW'(V_ACTIVE + V_FP)) &&
                         (v_count <  VW'(V_ACTIVE + V_FP + V_SYNC)));

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            h_count   <= '0;
            v_count   <= '0;
            line_base <= '0;
        end else begin
            h_count <= h_end ? '0 : h_count + 1'b1;
            if (h_end) begin
                v_count <= v_end ? '0 : v_count + 1'b1;
                // Each framebuffer row is shown on two lines: step after odd lines.
                if (v_end)
                    line_base <= '0;
                else if (v_count[0] && v_vis)
                    line_base <= line_base + 17'(FB_WIDTH);
            end
        end
    end

    // After the last visible line line_base points one row past the buffer;
    // vertical blanking issues 0 instead so no out-of-range address is ever seen.
    always_comb begin
        rgb_addr = line_base;
        if (!v_vis)
            rgb_addr = '0;
        else if (h_vis)
            rgb_addr = line_base + 17'(h_count >> 1);
    end

    assign bus.framebuffer_rgb_addr     = rgb_addr;
    assign bus.framebuffer_palette_addr = bus.framebuffer_rgb_out;

    // display_on only changes at the frame origin so a frame is never half lit.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            oe_sync    <= '0;
            display_on <= 1'b0;
        end else begin
            oe_sync <= {oe_sync[0], output_enabled};
            if (h_count == '0 && v_count == '0)
                display_on <= oe_sync[1];
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            de_pipe                <= '0;
            hs_pipe                <= '1;
            vs_pipe                <= '1;
            bus.video_rgb          <= '0;
            bus.video_de           <= 1'b0;
            bus.video_hsync        <= 1'b1;
            bus.video_vsync        <= 1'b1;
            bus.framebuffer_hblank <= 1'b0;
            bus.framebuffer_vblank <= 1'b0;
        end else begin
            de_pipe                <= {de_pipe[0], active};
            hs_pipe                <= {hs_pipe[0], hsync_raw};
            vs_pipe                <= {vs_pipe[0], vsync_raw};
            bus.video_de           <= de_pipe[1];
            bus.video_hsync        <= hs_pipe[1];
            bus.video_vsync        <= vs_pipe[1];
            bus.video_rgb          <= (de_pipe[1] && display_on) ? bus.framebuffer_palette_out : '0;
            // Status flags track the counters directly, not the video pipeline.
            bus.framebuffer_hblank <= !h_vis;
            bus.framebuffer_vblank <= !v_vis;
        end
    end
endmodule
